x_demux_ddr_mpc: RTL and testbench

X_DEMUX_DDR_MPC -- requirements
Module: x_demux_ddr_mpc

---
 rtl/x_demux_ddr_mpc.sv | 180 ++++++++++++++++++
 tb/tb_x_demux_ddr_mpc.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/x_demux_ddr_mpc.sv
`default_nettype none
// ============================================================================
//  Module   : x_demux_ddr_mpc
//  Purpose  : Demultiplexes a DDR MPC bus captured by an IDDR (rise/fall
//             samples) into ordered 1st/2nd-in-time words. An alignment FSM
//             hunts for the PAT1ST/PAT2ND word pair to pick the half-period
//             phase, confirms it LOCK_COUNT times, then locks.
//  Options  : MPC_RX_ERRCNT_EN - adds err_count, a saturating count of
//             mismatches seen while confirming alignment.
//  Revision : 1.0 - initial release
// ============================================================================
module x_demux_ddr_mpc #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] PAT1ST     = WIDTH'(8'hA5),
   parameter logic [WIDTH-1:0] PAT2ND     = WIDTH'(8'h5A),
   parameter int               LOCK_COUNT = 4,
   parameter int               TIMEOUT    = 1024
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clock_en,
   input  logic             align_req,
   input  logic [WIDTH-1:0] din_rise,
   input  logic [WIDTH-1:0] din_fall,
   output logic [WIDTH-1:0] dout1st,
   output logic [WIDTH-1:0] dout2nd,
   output logic             dout_valid,
   output logic             locked,
   output logic             phase,
   output logic             align_fail
`ifdef MPC_RX_ERRCNT_EN
   ,
   output logic [7:0]       err_count
`endif
);

   localparam int MW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [MW-1:0] LOCK_VAL = MW'(LOCK_COUNT);
   localparam logic [TW-1:0] TMO_VAL  = TW'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SEARCH  = 3'd1,
      S_CONFIRM = 3'd2,
      S_LOCKED  = 3'd3,
      S_FAIL    = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] fall_prev_q, fall_prev_d;
   logic [WIDTH-1:0] dout1st_q, dout1st_d;
   logic [WIDTH-1:0] dout2nd_q, dout2nd_d;
   logic [MW-1:0]    match_q, match_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic             phase_q, phase_d;
   logic             locked_q, locked_d;
   logic             align_fail_q, align_fail_d;
`ifdef MPC_RX_ERRCNT_EN
   logic [7:0]       err_q, err_d;
`endif

   // Pattern detectors for both candidate pairings; the shifted pairing takes
   // its 1st-in-time word from the previous cycle's falling-edge sample.
   logic norm_match, shift_match, sel_match;
   assign norm_match  = (din_rise == PAT1ST) && (din_fall == PAT2ND);
   assign shift_match = (fall_prev_q == PAT1ST) && (din_rise == PAT2ND);
   assign sel_match   = phase_q ? shift_match : norm_match;

   // Next-state, counters and data path; everything holds when clock_en is low.
   always_comb begin
      state_d      = state_q;
      fall_prev_d  = fall_prev_q;
      dout1st_d    = dout1st_q;
      dout2nd_d    = dout2nd_q;
      match_d      = match_q;
      tmo_d        = tmo_q;
      phase_d      = phase_q;
      locked_d     = locked_q;
      align_fail_d = align_fail_q;
`ifdef MPC_RX_ERRCNT_EN
      err_d        = err_q;
`endif
      if (clock_en) begin
         fall_prev_d = din_fall;
         // Data path runs in every state; dout_valid alone qualifies it.
         dout1st_d   = phase_q ? fall_prev_q : din_rise;
         dout2nd_d   = phase_q ? din_rise    : din_fall;
         if (align_req) begin
            state_d      = S_SEARCH;
            match_d      = '0;
            tmo_d        = '0;
            locked_d     = 1'b0;
            align_fail_d = 1'b0;
         end else begin
            case (state_q)
               S_SEARCH, S_CONFIRM: begin
                  tmo_d = tmo_q + 1'b1;
                  if (state_q == S_SEARCH) begin
                     // Normal pairing wins if both pairings happen to match.
                     if (norm_match) begin
                        phase_d = 1'b0;
                        match_d = MW'(1);
                        state_d = S_CONFIRM;
                     end else if (shift_match) begin
                        phase_d = 1'b1;
                        match_d = MW'(1);
                        state_d = S_CONFIRM;
                     end
                  end else if (sel_match) begin
                     match_d = match_q + 1'b1;
                  end else begin
                     match_d = '0;
                     state_d = S_SEARCH;
`ifdef MPC_RX_ERRCNT_EN
                     if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                     end
`endif
                  end
                  // Running out of time beats a lock landing on the same edge.
                  if (tmo_d == TMO_VAL) begin
                     state_d      = S_FAIL;
                     align_fail_d = 1'b1;
                     match_d      = '0;
                  end else if ((state_d == S_CONFIRM) && (match_d == LOCK_VAL)) begin
                     state_d  = S_LOCKED;
                     locked_d = 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   // State register with synchronous active-low reset to the blanked idle level.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         fall_prev_q  <= '1;
         dout1st_q    <= '1;
         dout2nd_q    <= '1;
         match_q      <= '0;
         tmo_q        <= '0;
         phase_q      <= 1'b0;
         locked_q     <= 1'b0;
         align_fail_q <= 1'b0;
`ifdef MPC_RX_ERRCNT_EN
         err_q        <= 8'd0;
`endif
      end else begin
         state_q      <= state_d;
         fall_prev_q  <= fall_prev_d;
         dout1st_q    <= dout1st_d;
         dout2nd_q    <= dout2nd_d;
         match_q      <= match_d;
         tmo_q        <= tmo_d;
         phase_q      <= phase_d;
         locked_q     <= locked_d;
         align_fail_q <= align_fail_d;
`ifdef MPC_RX_ERRCNT_EN
         err_q        <= err_d;
`endif
      end
   end

   assign dout1st    = dout1st_q;
   assign dout2nd    = dout2nd_q;
   assign dout_valid = (state_q == S_LOCKED) && clock_en;
   assign locked     = locked_q;
   assign phase      = phase_q;
   assign align_fail = align_fail_q;
`ifdef MPC_RX_ERRCNT_EN
   assign err_count  = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_x_demux_ddr_mpc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_x_demux_ddr_mpc
//  Purpose  : Scoreboard bench for x_demux_ddr_mpc. A behavioural model
//             predicts the outputs after every clock edge; a monitor compares
//             them. Honours MPC_RX_ERRCNT_EN for the err_count port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_x_demux_ddr_mpc;

   localparam int         WIDTH = 8;
   localparam logic [7:0] P1    = 8'hA5;
   localparam logic [7:0] P2    = 8'h5A;
   localparam int         LOCKN = 4;
   localparam int         TMO   = 1024;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       clock_en = 1'b0;
   logic       align_req = 1'b0;
   logic [7:0] din_rise = 8'h00;
   logic [7:0] din_fall = 8'h00;
   logic [7:0] dout1st, dout2nd;
   logic       dout_valid, locked, phase, align_fail;
`ifdef MPC_RX_ERRCNT_EN
   logic [7:0] err_count;
`endif

   x_demux_ddr_mpc #(
      .WIDTH(WIDTH), .PAT1ST(P1), .PAT2ND(P2), .LOCK_COUNT(LOCKN), .TIMEOUT(TMO)
   ) dut (
      .clock(clock), .reset_n(reset_n), .clock_en(clock_en), .align_req(align_req),
      .din_rise(din_rise), .din_fall(din_fall), .dout1st(dout1st), .dout2nd(dout2nd),
      .dout_valid(dout_valid), .locked(locked), .phase(phase), .align_fail(align_fail)
`ifdef MPC_RX_ERRCNT_EN
      , .err_count(err_count)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] d1, d2;
      bit lk, ph, af, dv;
      int err;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int failures = 0;

   // Behavioural model: "hunting" for the alignment pair, the length of the
   // current run of good pairs, and how long the hunt has lasted.
   logic [7:0] m_d1 = 8'hFF, m_d2 = 8'hFF, m_fprev = 8'hFF;
   bit m_phase = 0, m_locked = 0, m_fail = 0, m_hunting = 0;
   int m_run = 0, m_spent = 0, m_err = 0;

   task automatic model_step(input logic [7:0] r, input logic [7:0] f,
                             input bit en, input bit areq, input bit rstn);
      logic [7:0] n1, n2;
      if (!rstn) begin
         m_d1 = 8'hFF; m_d2 = 8'hFF; m_fprev = 8'hFF;
         m_phase = 0; m_locked = 0; m_fail = 0; m_hunting = 0;
         m_run = 0; m_spent = 0; m_err = 0;
         return;
      end
      if (!en) return;
      // Output words follow the phase chosen before this edge.
      n1 = m_phase ? m_fprev : r;
      n2 = m_phase ? r : f;
      if (areq) begin
         m_hunting = 1; m_run = 0; m_spent = 0; m_locked = 0; m_fail = 0;
      end else if (m_hunting) begin
         m_spent++;
         if (m_run == 0) begin
            if (r == P1 && f == P2) begin m_phase = 0; m_run = 1; end
            else if (m_fprev == P1 && r == P2) begin m_phase = 1; m_run = 1; end
         end else if ((m_phase ? {m_fprev, r} : {r, f}) == {P1, P2}) begin
            m_run++;
         end else begin
            m_run = 0;
            if (m_err < 255) m_err++;
         end
         if (m_spent >= TMO) begin
            m_hunting = 0; m_fail = 1; m_run = 0;
         end else if (m_run >= LOCKN) begin
            m_hunting = 0; m_locked = 1;
         end
      end
      m_fprev = f; m_d1 = n1; m_d2 = n2;
   endtask

   // One bus cycle: drive inputs on the falling edge, predict the response.
   task automatic cyc(input logic [7:0] r, input logic [7:0] f,
                      input bit en = 1, input bit areq = 0, input bit rstn = 1);
      exp_t e;
      @(negedge clock);
      din_rise = r; din_fall = f; clock_en = en; align_req = areq; reset_n = rstn;
      model_step(r, f, en, areq, rstn);
      e.d1 = m_d1; e.d2 = m_d2; e.lk = m_locked; e.ph = m_phase; e.af = m_fail;
      e.dv = m_locked && en; e.err = m_err;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
      end
   endtask

   // Monitor: every edge the DUT presents a result; pop and compare.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("dout1st", int'(dout1st), int'(e.d1));
            chk("dout2nd", int'(dout2nd), int'(e.d2));
            chk("locked", int'(locked), int'(e.lk));
            chk("phase", int'(phase), int'(e.ph));
            chk("align_fail", int'(align_fail), int'(e.af));
            chk("dout_valid", int'(dout_valid), int'(e.dv));
`ifdef MPC_RX_ERRCNT_EN
            chk("err_count", int'(err_count), e.err);
`endif
         end
      end
   end

   function automatic logic [7:0] pick();
      case ($urandom_range(0, 3))
         0: return P1;
         1: return P2;
         2: return 8'h00;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      logic [7:0] s[$];
      // Reset, then normal-phase lock and a data word.
      cyc(8'h00, 8'h00, 1, 0, 0);
      cyc(8'h00, 8'h00, 1, 0, 0);
      cyc(8'h00, 8'h00, 1, 1);
      for (int i = 0; i < 4; i++) cyc(P1, P2);
      cyc(8'h12, 8'h34);
      for (int i = 0; i < 6; i++) cyc(8'($urandom), 8'($urandom));

      // Bus shifted by half a period: stream words land rise=odd, fall=even.
      for (int i = 0; i < 6; i++) begin s.push_back(P1); s.push_back(P2); end
      s.push_back(8'h12); s.push_back(8'h34); s.push_back(8'h56);
      s.push_back(8'h78); s.push_back(8'h9A); s.push_back(8'hBC);
      for (int i = 0; i < 6; i++) s.push_back(8'($urandom));
      for (int k = 0; 2 * k + 2 < s.size(); k++)
         cyc(s[2*k+1], s[2*k+2], 1, (k == 0));

      // Two matches, a corrupt pair, then four matches.
      cyc(8'h00, 8'h00, 1, 1);
      cyc(P1, P2); cyc(P1, P2);
      cyc(P1, 8'h00);
      for (int i = 0; i < 4; i++) cyc(P1, P2);
      cyc(8'hC3, 8'h3C);

      // Alignment timeout, then clearing it with a new request.
      cyc(8'h00, 8'h00, 1, 1);
      for (int i = 0; i < TMO + 3; i++) cyc(8'h00, 8'h00);
      cyc(8'h00, 8'h00, 1, 1);
      cyc(8'h00, 8'h00);

      // Clock enable dropped mid-confirmation, garbage data while disabled.
      cyc(8'h00, 8'h00, 1, 1);
      cyc(P1, P2); cyc(P1, P2);
      for (int i = 0; i < 3; i++) cyc(8'($urandom), 8'($urandom), 0);
      cyc(P1, P2); cyc(P1, P2);
      cyc(8'h11, 8'h22);

      // Reset while locked.
      cyc(8'h44, 8'h55, 1, 0, 0);
      cyc(8'h66, 8'h77);

      // Randomised traffic.
      cyc(8'h00, 8'h00, 1, 1);
      for (int i = 0; i < 3000; i++)
         cyc(pick(), pick(), ($urandom_range(0, 7) != 0),
             ($urandom_range(0, 59) == 0), ($urandom_range(0, 499) != 0));

      cyc(8'h00, 8'h00);
      repeat (3) @(posedge clock);
      #2;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
